cache_rd_arbiter: RTL and testbench

- Shares one AXI-style read channel between the ICache refill path and the DCache refill/uncached-load path.
- Sequences one burst at a time: select requester, issue the AR transaction, steer R beats back to the owner, count beats, release.
- The DCache side is what drives the MEM stage's dcache_busy. Arbitration latency here directly adds to MEM-stage stall cycles, so DCache gets priority by default.

---
 rtl/cache_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_cache_rd_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter
//   Shares one AXI-style read channel between the ICache refill path and the
//   DCache refill/uncached-load path. Only one burst is in flight at a time:
//   pick a requester, issue AR, steer R beats to the owner, count beats, release.
//   DCache wins ties by default because its latency stalls the MEM stage.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on simultaneous requests (last_grant reg,
//                           reset to ICache)
//              undefined -> fixed DCache priority
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ic_rd_req/addr/len/ack     ICache request side (req held until ack)
//   ic_ret_valid/last/data     ICache return beats
//   dc_rd_req/addr/len/ack     DCache request side (req held until ack)
//   dc_ret_valid/last/data     DCache return beats
//   arvalid/arready/araddr/arlen/arsize/arburst/arid   AXI AR channel
//   rvalid/rready/rdata/rlast  AXI R channel (rid ignored, owner tracked here)
//   rd_err                     one-cycle pulse on beat count / rlast mismatch
module cache_rd_arbiter #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] IC_ID  = 4'd0,
  parameter logic [3:0] DC_ID  = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  input  logic [7:0]        ic_rd_len,
  output logic              ic_rd_ack,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  input  logic [7:0]        dc_rd_len,
  output logic              dc_rd_ack,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  output logic              rd_err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_own_dc;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [3:0]        r_arid;
  logic [7:0]        r_cnt;

  logic w_any_req, w_pick_dc, w_prio_dc;
  logic w_ar_hs, w_beat, w_done, w_len_hit;

  assign w_any_req = ic_rd_req | dc_rd_req;
  assign w_ar_hs   = (r_state == S_AR) && arready;
  assign w_beat    = (r_state == S_R) && rvalid;
  assign w_done    = w_beat && rlast;
  // Compared before the increment, so len=255 reaches 255 on its last beat
  // without wrapping.
  assign w_len_hit = (r_cnt == r_arlen);

`ifdef ARB_RR_EN
  // 1 = DCache owned the most recent completed burst.
  logic r_last_dc;
  always_ff @(posedge clk) begin
    if (reset)       r_last_dc <= 1'b0;
    else if (w_done) r_last_dc <= r_own_dc;
  end
  assign w_prio_dc = ~r_last_dc;
`else
  assign w_prio_dc = 1'b1;
`endif

  // Tie-break only matters when both request in the same IDLE cycle.
  assign w_pick_dc = dc_rd_req && (!ic_rd_req || w_prio_dc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_own_dc <= 1'b0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arid   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any_req) begin
        r_own_dc <= w_pick_dc;
        r_araddr <= w_pick_dc ? dc_rd_addr : ic_rd_addr;
        r_arlen  <= w_pick_dc ? dc_rd_len  : ic_rd_len;
        r_arid   <= w_pick_dc ? DC_ID      : IC_ID;
      end
      if (w_ar_hs)     r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    ic_rd_ack   = 1'b0;
    dc_rd_ack   = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_any_req) w_state_nxt = S_AR;
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          ic_rd_ack   = ~r_own_dc;
          dc_rd_ack   = r_own_dc;
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Return path is purely combinational: zero added latency to the owner.
  assign ic_ret_valid = w_beat && !r_own_dc;
  assign ic_ret_last  = w_beat && !r_own_dc && rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_valid = w_beat && r_own_dc;
  assign dc_ret_last  = w_beat && r_own_dc && rlast;
  assign dc_ret_data  = rdata;

  // Early rlast or missing rlast at the expected final beat; the burst still
  // ends only on rlast.
  assign rd_err = w_beat && (rlast != w_len_hit);

  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arid    = r_arid;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
module tb_cache_rd_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ic_rd_req, dc_rd_req;
  logic [31:0] ic_rd_addr, dc_rd_addr;
  logic [7:0]  ic_rd_len, dc_rd_len;
  logic        ic_rd_ack, dc_rd_ack;
  logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
  logic [31:0] ic_ret_data, dc_ret_data;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid, rready, rlast, rd_err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  cache_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_len(ic_rd_len), .ic_rd_ack(ic_rd_ack),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_len(dc_rd_len), .dc_rd_ack(dc_rd_ack),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .rd_err(rd_err)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ic_rd_req = 0; dc_rd_req = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
  endtask

  // {arvalid, rready, ic_ack, dc_ack, ic_rv, ic_rl, dc_rv, dc_rl, rd_err}
  function automatic logic [8:0] obs();
    return {arvalid, rready, ic_rd_ack, dc_rd_ack, ic_ret_valid, ic_ret_last,
            dc_ret_valid, dc_ret_last, rd_err};
  endfunction

  typedef struct {
    logic       icq, dcq, ardy, rv, rl;
    logic [7:0] iclen, dclen;
    logic [8:0] exp;
    logic [3:0] eid;
  } vec_t;

  function automatic vec_t mk(input logic icq, dcq, ardy, rv, rl,
                              input logic [7:0] il, dl, input logic [8:0] e,
                              input logic [3:0] id);
    vec_t v;
    v.icq = icq; v.dcq = dcq; v.ardy = ardy; v.rv = rv; v.rl = rl;
    v.iclen = il; v.dclen = dl; v.exp = e; v.eid = id;
    return v;
  endfunction

  localparam logic [31:0] IC_A = 32'h0000_1000;
  localparam logic [31:0] DC_A = 32'h1fc0_0040;

  // Random-phase model state
  bit          ic_pend, dc_pend, prev_icq, prev_dcq, prev_arv;
  bit          own_dc, in_ar, in_r, mdl_last_dc, exp_dc;
  logic [31:0] ic_a, dc_a, exp_a;
  logic [7:0]  ic_l, dc_l, exp_l;
  int          ic_todo, dc_todo, beats_left;

  function automatic logic [7:0] rand_len();
    return ($urandom_range(15) == 0) ? 8'd255 : 8'($urandom_range(7));
  endfunction

  initial begin
    vec_t vt[$];
    vec_t v;
    logic [31:0] d;

    clr();
    ic_rd_addr = IC_A; dc_rd_addr = DC_A; ic_rd_len = 0; dc_rd_len = 0;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arid", arid, 0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);

    // ---------------- table-driven vectors ----------------
    vt.push_back(mk(0,0,0,0,0, 0,0, 9'b000000000, 0)); // reset state
    vt.push_back(mk(0,1,0,0,0, 0,3, 9'b000000000, 0)); // dc req sampled
    vt.push_back(mk(0,1,1,0,0, 0,3, 9'b100100000, 1)); // AR + ack
    vt.push_back(mk(0,0,0,1,0, 0,3, 9'b010000100, 0));
    vt.push_back(mk(0,0,0,1,0, 0,3, 9'b010000100, 0));
    vt.push_back(mk(0,0,0,0,0, 0,3, 9'b010000000, 0)); // R gap
    vt.push_back(mk(0,0,0,1,0, 0,3, 9'b010000100, 0));
    vt.push_back(mk(0,0,0,1,1, 0,3, 9'b010000110, 0)); // beat 4 last
    vt.push_back(mk(0,0,0,0,0, 0,3, 9'b000000000, 0));
    vt.push_back(mk(0,1,0,0,0, 0,3, 9'b000000000, 0)); // early rlast case
    vt.push_back(mk(0,1,1,0,0, 0,3, 9'b100100000, 1));
    vt.push_back(mk(0,0,0,1,0, 0,3, 9'b010000100, 0));
    vt.push_back(mk(0,0,0,1,1, 0,3, 9'b010000111, 0)); // rlast on beat 2 of 4
    vt.push_back(mk(0,0,0,0,0, 0,3, 9'b000000000, 0));
    vt.push_back(mk(0,1,0,0,0, 0,1, 9'b000000000, 0)); // missing rlast case
    vt.push_back(mk(0,1,1,0,0, 0,1, 9'b100100000, 1));
    vt.push_back(mk(0,0,0,1,0, 0,1, 9'b010000100, 0));
    vt.push_back(mk(0,0,0,1,0, 0,1, 9'b010000101, 0)); // beat 2 of 2, no rlast
    vt.push_back(mk(0,0,0,1,1, 0,1, 9'b010000111, 0)); // late rlast also errors
    vt.push_back(mk(0,0,0,0,0, 0,1, 9'b000000000, 0));
    vt.push_back(mk(1,1,0,0,0, 0,0, 9'b000000000, 0)); // simultaneous
    vt.push_back(mk(1,1,1,0,0, 0,0, 9'b100100000, 1)); // dc wins
    vt.push_back(mk(1,0,0,1,1, 0,0, 9'b010000110, 0));
    vt.push_back(mk(1,0,0,0,0, 0,0, 9'b000000000, 0)); // 1 idle cycle
    vt.push_back(mk(1,0,1,0,0, 0,0, 9'b101000000, 0)); // ic AR + ack
    vt.push_back(mk(0,0,0,1,1, 0,0, 9'b010011000, 0));
    vt.push_back(mk(0,0,0,0,0, 0,0, 9'b000000000, 0));

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      ic_rd_req = v.icq; dc_rd_req = v.dcq; ic_rd_len = v.iclen; dc_rd_len = v.dclen;
      arready = v.ardy; rvalid = v.rv; rlast = v.rl; rdata = $urandom;
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(obs()), 32'(v.exp));
      if (v.exp[8]) begin
        chk($sformatf("vec%0d_arid", i), arid, v.eid);
        chk($sformatf("vec%0d_araddr", i), araddr, (v.eid == 4'd1) ? DC_A : IC_A);
      end
      if (v.exp[4]) chk($sformatf("vec%0d_icdata", i), ic_ret_data, rdata);
      if (v.exp[2]) chk($sformatf("vec%0d_dcdata", i), dc_ret_data, rdata);
      cyc();
    end
    clr();

    // ---------------- arready stall: address stable 6 cycles ----------------
    dc_rd_req = 1; dc_rd_addr = 32'h2000_0080; dc_rd_len = 5;
    #1; chk("stall_idle_arvalid", arvalid, 0); cyc();
    for (int i = 0; i < 6; i++) begin
      arready = (i == 5);
      #1;
      chk("stall_arvalid", arvalid, 1);
      chk("stall_araddr", araddr, 32'h2000_0080);
      chk("stall_arlen", arlen, 5);
      chk("stall_arid", arid, 1);
      chk("stall_dcack", dc_rd_ack, (i == 5));
      chk("stall_icack", ic_rd_ack, 0);
      cyc();
    end
    dc_rd_req = 0; arready = 0;
    for (int b = 0; b < 6; b++) begin
      rvalid = 1; rlast = (b == 5); rdata = 32'h100 + b;
      #1;
      chk("stall_dcrv", dc_ret_valid, 1);
      chk("stall_dcdata", dc_ret_data, 32'h100 + b);
      chk("stall_dcrl", dc_ret_last, (b == 5));
      chk("stall_err", rd_err, 0);
      cyc();
    end
    clr();

    // ---------------- simultaneous len=7, three rounds from reset ----------------
    reset = 1; cyc(); reset = 0;
    for (int rep = 0; rep < 3; rep++) begin
      ic_rd_req = 1; ic_rd_addr = 32'h0000_3000 + 32'(rep * 64); ic_rd_len = 7;
      dc_rd_req = 1; dc_rd_addr = 32'h1fc0_0040 + 32'(rep * 64); dc_rd_len = 7;
      cyc();
      arready = 1; #1;
      chk("sim_first_arid", arid, 1);
      chk("sim_first_dcack", dc_rd_ack, 1);
      cyc();
      dc_rd_req = 0; arready = 0;
      for (int b = 0; b < 8; b++) begin
        rvalid = 1; rlast = (b == 7); #1;
        chk("sim_dc_rv", dc_ret_valid, 1);
        chk("sim_ic_rv_quiet", ic_ret_valid, 0);
        cyc();
      end
      rvalid = 0; rlast = 0; #1;
      chk("sim_gap_arvalid", arvalid, 0);
      cyc();
      arready = 1; #1;
      chk("sim_ic_arvalid", arvalid, 1);
      chk("sim_ic_araddr", araddr, 32'h0000_3000 + 32'(rep * 64));
      chk("sim_ic_arid", arid, 0);
      chk("sim_ic_ack", ic_rd_ack, 1);
      cyc();
      ic_rd_req = 0; arready = 0;
      for (int b = 0; b < 8; b++) begin
        rvalid = 1; rlast = (b == 7); #1;
        chk("sim_ic_rv", ic_ret_valid, 1);
        chk("sim_dc_rv_quiet", dc_ret_valid, 0);
        cyc();
      end
      clr(); cyc();
    end

    // ---------------- reset during beat 2 of an 8-beat burst ----------------
    dc_rd_req = 1; dc_rd_addr = 32'h1fc0_0100; dc_rd_len = 7;
    cyc();
    arready = 1; cyc();
    dc_rd_req = 0; arready = 0; rvalid = 1; #1;
    chk("rstmid_beat1", dc_ret_valid, 1);
    cyc();
    reset = 1; #1;
    cyc();
    reset = 0; rvalid = 0; #1;
    chk("rstmid_outs", 32'(obs()), 0);
    chk("rstmid_araddr", araddr, 0);
    chk("rstmid_arlen", arlen, 0);
    chk("rstmid_arid", arid, 0);
    cyc();
    dc_rd_req = 1; dc_rd_addr = 32'h1fc0_0200; dc_rd_len = 0;
    cyc();
    arready = 1; #1;
    chk("rstmid_new_ack", dc_rd_ack, 1);
    chk("rstmid_new_araddr", araddr, 32'h1fc0_0200);
    cyc();
    dc_rd_req = 0; arready = 0; rvalid = 1; rlast = 1; #1;
    chk("rstmid_new_last", {dc_ret_valid, dc_ret_last, rd_err}, 3'b110);
    cyc();
    clr();

    // ---------------- randomized traffic vs transaction-level model ----------------
    reset = 1; cyc(); reset = 0;
    ic_pend = 0; dc_pend = 0; prev_icq = 0; prev_dcq = 0; prev_arv = 0;
    in_ar = 0; in_r = 0; own_dc = 0; mdl_last_dc = 0; beats_left = 0;
    ic_todo = 25; dc_todo = 25;
    ic_a = 0; dc_a = 0; ic_l = 0; dc_l = 0; exp_a = 0; exp_l = 0;
    for (int c = 0; c < 30000; c++) begin
      if (!(ic_todo > 0 || dc_todo > 0 || ic_pend || dc_pend || in_ar || in_r)) break;
      if (!ic_pend && ic_todo > 0 && $urandom_range(3) == 0) begin
        ic_pend = 1; ic_todo--; ic_a = $urandom & ~32'h3; ic_l = rand_len();
      end
      if (!dc_pend && dc_todo > 0 && $urandom_range(3) == 0) begin
        dc_pend = 1; dc_todo--; dc_a = $urandom & ~32'h3; dc_l = rand_len();
      end
      ic_rd_req = ic_pend; ic_rd_addr = ic_a; ic_rd_len = ic_l;
      dc_rd_req = dc_pend; dc_rd_addr = dc_a; dc_rd_len = dc_l;
      arready = ($urandom_range(2) != 0);
      rvalid  = in_r && ($urandom_range(3) != 0);
      rlast   = rvalid && (beats_left == 1);
      d = $urandom; rdata = d;
      #1;
      if (arvalid && !prev_arv) begin
        // a new address phase: winner chosen from requests seen while idle
        chk("rnd_grant_has_req", 32'(prev_icq | prev_dcq), 1);
        if (prev_icq && prev_dcq) begin
`ifdef ARB_RR_EN
          exp_dc = !mdl_last_dc;
`else
          exp_dc = 1;
`endif
        end else exp_dc = prev_dcq;
        own_dc = exp_dc;
        exp_a  = own_dc ? dc_a : ic_a;
        exp_l  = own_dc ? dc_l : ic_l;
        in_ar  = 1;
      end
      chk("rnd_rready", rready, in_r);
      if (in_ar) begin
        chk("rnd_arid", arid, own_dc ? 4'd1 : 4'd0);
        chk("rnd_araddr", araddr, exp_a);
        chk("rnd_arlen", arlen, exp_l);
      end
      chk("rnd_icack", ic_rd_ack, in_ar && arready && !own_dc);
      chk("rnd_dcack", dc_rd_ack, in_ar && arready && own_dc);
      chk("rnd_icrv", ic_ret_valid, in_r && rvalid && !own_dc);
      chk("rnd_dcrv", dc_ret_valid, in_r && rvalid && own_dc);
      chk("rnd_icrl", ic_ret_last, in_r && rlast && !own_dc);
      chk("rnd_dcrl", dc_ret_last, in_r && rlast && own_dc);
      chk("rnd_err", rd_err, 0);
      if (in_r && rvalid) chk("rnd_data", own_dc ? dc_ret_data : ic_ret_data, d);
      if (in_ar && arready) begin
        in_ar = 0; in_r = 1; beats_left = int'(exp_l) + 1;
        if (own_dc) dc_pend = 0; else ic_pend = 0;
      end else if (in_r && rvalid) begin
        beats_left--;
        if (beats_left == 0) begin in_r = 0; mdl_last_dc = own_dc; end
      end
      prev_icq = ic_rd_req; prev_dcq = dc_rd_req; prev_arv = arvalid;
      cyc();
    end
    chk("rnd_all_served", 32'(ic_todo + dc_todo + int'(ic_pend) + int'(dc_pend) + int'(in_ar) + int'(in_r)), 0);
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
